// File: rtl/cache_refill_controller_if.sv
// Bundle of signals between the refill controller, the cache lookup path,
// the cache data/tag arrays and the single-word memory port.
// The master modport is the refill controller's view; the slave modport is the environment's.
interface cache_refill_controller_if #(
    parameter int WAYS        = 4,
    parameter int TAG_BITS    = 18,
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 6,
    parameter int DATA_WIDTH  = 32
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int WORD_W = OFFSET_BITS - 2;
    localparam int ADDR_W = TAG_BITS + INDEX_BITS + OFFSET_BITS;

    // Miss request from the lookup path
    logic                       miss_valid;
    logic                       miss_ready;
    logic [TAG_BITS-1:0]        miss_tag;
    logic [INDEX_BITS-1:0]      miss_index;
    logic [WAYS-1:0]            set_valid;
    logic [WAYS-1:0]            set_dirty;
    logic [WAYS*TAG_BITS-1:0]   set_tags;

    // Victim read port of the data array
    logic                       cache_rd_en;
    logic [WAY_W-1:0]           cache_rd_way;
    logic [INDEX_BITS-1:0]      cache_rd_index;
    logic [WORD_W-1:0]          cache_rd_word;
    logic [DATA_WIDTH-1:0]      cache_rd_data;

    // Refill write port of the data array and tag update
    logic                       fill_we;
    logic [WAY_W-1:0]           fill_way;
    logic [INDEX_BITS-1:0]      fill_index;
    logic [WORD_W-1:0]          fill_word;
    logic [DATA_WIDTH-1:0]      fill_data;
    logic                       tag_we;

    // Single-word memory port
    logic                       mem_req;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic                       mem_ack;
    logic [DATA_WIDTH-1:0]      mem_rdata;

    // Completion
    logic                       done;
    logic [WAY_W-1:0]           done_way;

    modport master (
        input  miss_valid, miss_tag, miss_index, set_valid, set_dirty, set_tags,
        output miss_ready,
        output cache_rd_en, cache_rd_way, cache_rd_index, cache_rd_word,
        input  cache_rd_data,
        output fill_we, fill_way, fill_index, fill_word, fill_data, tag_we,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output done, done_way
    );

    modport slave (
        output miss_valid, miss_tag, miss_index, set_valid, set_dirty, set_tags,
        input  miss_ready,
        input  cache_rd_en, cache_rd_way, cache_rd_index, cache_rd_word,
        output cache_rd_data,
        input  fill_we, fill_way, fill_index, fill_word, fill_data, tag_we,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  done, done_way
    );
endinterface

// File: rtl/cache_refill_controller.sv
// Miss-handling sequencer for a set-associative cache: picks a victim way,
// writes a dirty victim back word by word, refills the line from memory and
// then issues the tag/valid update.
module cache_refill_controller #(
    parameter int WAYS            = 4,
    parameter int TAG_BITS        = 18,
    parameter int INDEX_BITS      = 8,
    parameter int OFFSET_BITS     = 6,
    parameter int DATA_WIDTH      = 32,
    parameter int LINE_SIZE_BYTES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    cache_refill_controller_if.master bus
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int WORD_W = OFFSET_BITS - 2;
    localparam int WORDS  = LINE_SIZE_BYTES * 8 / DATA_WIDTH;

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);
    localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB_RD  = 3'd1;
    localparam logic [2:0] S_WB_WR  = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    logic [2:0]            state_q,     state_d;
    logic [WORD_W-1:0]     word_q,      word_d;
    logic [WAY_W-1:0]      rr_q,        rr_d;
    logic [WAY_W-1:0]      victim_q,    victim_d;
    logic [TAG_BITS-1:0]   vtag_q,      vtag_d;
    logic [TAG_BITS-1:0]   mtag_q,      mtag_d;
    logic [INDEX_BITS-1:0] index_q,     index_d;

    logic                  inv_found;
    logic [WAY_W-1:0]      inv_way;
    logic [WAY_W-1:0]      victim;
    logic [TAG_BITS-1:0]   victim_tag;
    logic                  victim_dirty;

    // Victim choice for the set presented with the miss: lowest invalid way, else round-robin
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        inv_found  = 1'b0;
        inv_way    = '0;
        victim_tag = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!bus.set_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : rr_q;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == victim) begin
                victim_tag = bus.set_tags[w*TAG_BITS +: TAG_BITS];
            end
        end
        victim_dirty = bus.set_valid[victim] & bus.set_dirty[victim];
    end

    // Next-state logic for the sequencer, word counter, round-robin pointer and latched miss
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        rr_d     = rr_q;
        victim_d = victim_q;
        vtag_d   = vtag_q;
        mtag_d   = mtag_q;
        index_d  = index_q;
        case (state_q)
            S_IDLE: begin
                if (bus.miss_valid) begin
                    mtag_d   = bus.miss_tag;
                    index_d  = bus.miss_index;
                    victim_d = victim;
                    vtag_d   = victim_tag;
                    word_d   = '0;
                    // The pointer only moves when the set was full and it supplied the victim
                    if (!inv_found) begin
                        rr_d = (rr_q == LAST_WAY) ? '0 : rr_q + WAY_W'(1);
                    end
                    state_d = victim_dirty ? S_WB_RD : S_FILL;
                end
            end
            S_WB_RD: begin
                state_d = S_WB_WR;
            end
            S_WB_WR: begin
                if (bus.mem_ack) begin
                    if (word_q == LAST_WORD) begin
                        word_d  = '0;
                        state_d = S_FILL;
                    end else begin
                        word_d  = word_q + WORD_W'(1);
                        state_d = S_WB_RD;
                    end
                end
            end
            S_FILL: begin
                if (bus.mem_ack) begin
                    if (word_q == LAST_WORD) begin
                        word_d  = '0;
                        state_d = S_UPDATE;
                    end else begin
                        word_d  = word_q + WORD_W'(1);
                    end
                end
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-refill simply abandons the line
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            state_q  <= S_IDLE;
            word_q   <= '0;
            rr_q     <= '0;
            victim_q <= '0;
            vtag_q   <= '0;
            mtag_q   <= '0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            rr_q     <= rr_d;
            victim_q <= victim_d;
            vtag_q   <= vtag_d;
            mtag_q   <= mtag_d;
            index_q  <= index_d;
        end
    end

    // Strobes are plain state decodes; address and data come straight from the latched miss
    assign bus.miss_ready     = (state_q == S_IDLE);

    assign bus.cache_rd_en    = (state_q == S_WB_RD);
    assign bus.cache_rd_way   = victim_q;
    assign bus.cache_rd_index = index_q;
    assign bus.cache_rd_word  = word_q;

    assign bus.fill_we        = (state_q == S_FILL) && bus.mem_ack;
    assign bus.fill_way       = victim_q;
    assign bus.fill_index     = index_q;
    assign bus.fill_word      = word_q;
    assign bus.fill_data      = bus.mem_rdata;
    assign bus.tag_we         = (state_q == S_UPDATE);

    assign bus.mem_req        = (state_q == S_WB_WR) || (state_q == S_FILL);
    assign bus.mem_we         = (state_q == S_WB_WR);
    assign bus.mem_addr       = {(state_q == S_WB_WR) ? vtag_q : mtag_q, index_q, word_q, 2'b00};
    assign bus.mem_wdata      = bus.cache_rd_data;

    assign bus.done           = (state_q == S_UPDATE);
    assign bus.done_way       = victim_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Scoreboard bench for cache_refill_controller: expected memory transfers and
// array writes are queued when a miss is issued and popped as the DUT performs them.
`timescale 1ns/1ps
module tb_cache_refill_controller;
    localparam int WAYS        = 4;
    localparam int TAG_BITS    = 18;
    localparam int INDEX_BITS  = 8;
    localparam int OFFSET_BITS = 6;
    localparam int DATA_WIDTH  = 32;
    localparam int LINE_BYTES  = 64;
    localparam int WORDS       = 16;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_txn_t;

    typedef struct {
        logic [1:0]  way;
        logic [7:0]  index;
        logic [3:0]  word;
        logic [31:0] data;
    } fill_txn_t;

    localparam logic [71:0] TAGS_A = {18'h33333, 18'h22222, 18'h11111, 18'h00001};
    localparam logic [71:0] TAGS_B = {18'h3C0DE, 18'h2BEEF, 18'h1F00D, 18'h0CAFE};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_refill_controller_if #(
        .WAYS(WAYS), .TAG_BITS(TAG_BITS), .INDEX_BITS(INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    cache_refill_controller #(
        .WAYS(WAYS), .TAG_BITS(TAG_BITS), .INDEX_BITS(INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS), .DATA_WIDTH(DATA_WIDTH), .LINE_SIZE_BYTES(LINE_BYTES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_txn_t  mem_q[$];
    fill_txn_t fill_q[$];

    int checks = 0;
    int errors = 0;

    // Monitor-recorded observations
    int          done_count   = 0;
    int          tag_we_count = 0;
    int          cyc          = 0;
    bit          running      = 1'b0;
    logic [1:0]  done_way_seen;
    logic [1:0]  tag_way_seen;
    logic [7:0]  tag_index_seen;
    bit          tag_with_done;
    int          done_cycle;
    bit          stalled_prev = 1'b0;
    logic [31:0] prev_addr;
    logic        prev_we;

    // Memory stall control
    int stall_word = -1;
    int stall_left = 0;

    function automatic logic [31:0] arr_word(input logic [1:0] way, input logic [7:0] idx,
                                             input logic [3:0] word);
        return {8'hA5, 6'd0, way, idx, 4'd0, word};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h5A5A_F00F;
    endfunction

    // Data array model: word for the strobed location appears the cycle after cache_rd_en
    initial begin
        logic [1:0] w;
        logic [7:0] ix;
        logic [3:0] wd;
        bus.cache_rd_data = '0;
        forever begin
            @(negedge clk);
            if (bus.cache_rd_en === 1'b1) begin
                w  = bus.cache_rd_way;
                ix = bus.cache_rd_index;
                wd = bus.cache_rd_word;
                @(posedge clk);
                #1 bus.cache_rd_data = arr_word(w, ix, wd);
            end
        end
    end

    // Memory responder and scoreboard monitor, both on the falling edge
    initial begin
        mem_txn_t  m;
        fill_txn_t f;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1 && bus.mem_we === 1'b0 && stall_left > 0 &&
                int'(bus.mem_addr[5:2]) == stall_word) begin
                bus.mem_ack = 1'b0;
                stall_left--;
            end else begin
                bus.mem_ack = 1'b1;
            end
            bus.mem_rdata = (bus.mem_req === 1'b1) ? mem_word(bus.mem_addr) : '0;
            #1;
            if (running) cyc++;
            if (bus.miss_valid === 1'b1 && bus.miss_ready === 1'b1 && rst === 1'b0) begin
                running = 1'b1;
                cyc     = 0;
            end

            if (bus.mem_req === 1'b1) begin
                if (stalled_prev) begin
                    checks++;
                    if (bus.mem_addr !== prev_addr || bus.mem_we !== prev_we) begin
                        errors++;
                        $display("FAIL mem_hold: addr %h we %b, required %h we %b",
                                 bus.mem_addr, bus.mem_we, prev_addr, prev_we);
                    end
                end
                if (bus.mem_ack === 1'b1) begin
                    stalled_prev = 1'b0;
                    checks++;
                    if (mem_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_unexpected: we %b addr %h, required no transfer",
                                 bus.mem_we, bus.mem_addr);
                    end else begin
                        m = mem_q.pop_front();
                        if (bus.mem_we !== m.we || bus.mem_addr !== m.addr ||
                            (m.we && bus.mem_wdata !== m.data)) begin
                            errors++;
                            $display("FAIL mem_txn: we %b addr %h wdata %h, required we %b addr %h wdata %h",
                                     bus.mem_we, bus.mem_addr, bus.mem_wdata, m.we, m.addr, m.data);
                        end
                    end
                end else begin
                    stalled_prev = 1'b1;
                    prev_addr    = bus.mem_addr;
                    prev_we      = bus.mem_we;
                end
            end else begin
                stalled_prev = 1'b0;
            end

            if (bus.fill_we === 1'b1) begin
                checks++;
                if (fill_q.size() == 0 || bus.mem_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_unexpected: word %0d ack %b, required no array write",
                             bus.fill_word, bus.mem_ack);
                end else begin
                    f = fill_q.pop_front();
                    if (bus.fill_way !== f.way || bus.fill_index !== f.index ||
                        bus.fill_word !== f.word || bus.fill_data !== f.data) begin
                        errors++;
                        $display("FAIL fill_txn: way %0d idx %h word %0d data %h, required way %0d idx %h word %0d data %h",
                                 bus.fill_way, bus.fill_index, bus.fill_word, bus.fill_data,
                                 f.way, f.index, f.word, f.data);
                    end
                end
            end

            if (bus.tag_we === 1'b1) begin
                tag_we_count++;
                tag_way_seen   = bus.fill_way;
                tag_index_seen = bus.fill_index;
                tag_with_done  = (bus.done === 1'b1);
            end
            if (bus.done === 1'b1) begin
                done_count++;
                done_cycle    = cyc;
                done_way_seen = bus.done_way;
                running       = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic push_expect(input logic [17:0] tag, input logic [7:0] idx,
                               input logic [1:0] victim, input logic [17:0] vtag, input bit dirty);
        mem_txn_t  m;
        fill_txn_t f;
        if (dirty) begin
            for (int w = 0; w < WORDS; w++) begin
                m.we   = 1'b1;
                m.addr = {vtag, idx, 4'(w), 2'b00};
                m.data = arr_word(victim, idx, 4'(w));
                mem_q.push_back(m);
            end
        end
        for (int w = 0; w < WORDS; w++) begin
            m.we    = 1'b0;
            m.addr  = {tag, idx, 4'(w), 2'b00};
            m.data  = mem_word(m.addr);
            mem_q.push_back(m);
            f.way   = victim;
            f.index = idx;
            f.word  = 4'(w);
            f.data  = m.data;
            fill_q.push_back(f);
        end
    endtask

    // Present a miss for one cycle, then scramble the set inputs so only latched values matter
    task automatic drive_miss(input string name, input logic [17:0] tag, input logic [7:0] idx,
                              input logic [3:0] valid, input logic [3:0] dirty, input logic [71:0] tags);
        @(posedge clk);
        #1;
        checks++;
        if (bus.miss_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: miss_ready %b, required 1", name, bus.miss_ready);
        end
        bus.miss_valid = 1'b1;
        bus.miss_tag   = tag;
        bus.miss_index = idx;
        bus.set_valid  = valid;
        bus.set_dirty  = dirty;
        bus.set_tags   = tags;
        @(posedge clk);
        #1;
        bus.miss_valid = 1'b0;
        bus.miss_tag   = ~tag;
        bus.miss_index = ~idx;
        bus.set_valid  = ~valid;
        bus.set_dirty  = ~dirty;
        bus.set_tags   = ~tags;
    endtask

    task automatic do_miss(input string name, input logic [17:0] tag, input logic [7:0] idx,
                           input logic [3:0] valid, input logic [3:0] dirty, input logic [71:0] tags,
                           input logic [1:0] victim, input int exp_cycle, input bit poke);
        int start_done;
        int start_tag;
        logic [17:0] vtag;
        vtag       = tags[int'(victim)*TAG_BITS +: TAG_BITS];
        start_done = done_count;
        start_tag  = tag_we_count;
        push_expect(tag, idx, victim, vtag, valid[victim] & dirty[victim]);
        drive_miss(name, tag, idx, valid, dirty, tags);
        if (poke) begin
            repeat (4) @(posedge clk);
            #1 bus.miss_valid = 1'b1;
            repeat (2) @(posedge clk);
            #1 bus.miss_valid = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            if (done_count != start_done) break;
            @(negedge clk);
            #2;
        end
        checks++;
        if (done_count == start_done) begin
            errors++;
            $display("FAIL %s_timeout: done count %0d, required %0d", name, done_count, start_done + 1);
        end else begin
            checks++;
            if (done_cycle != exp_cycle) begin
                errors++;
                $display("FAIL %s_latency: done in cycle %0d, required %0d", name, done_cycle, exp_cycle);
            end
            checks++;
            if (done_way_seen !== victim) begin
                errors++;
                $display("FAIL %s_done_way: %0d, required %0d", name, done_way_seen, victim);
            end
            checks++;
            if (tag_we_count != start_tag + 1 || tag_way_seen !== victim ||
                tag_index_seen !== idx || !tag_with_done) begin
                errors++;
                $display("FAIL %s_tag_we: count %0d way %0d idx %h with_done %b, required %0d way %0d idx %h with_done 1",
                         name, tag_we_count - start_tag, tag_way_seen, tag_index_seen, tag_with_done,
                         1, victim, idx);
            end
        end
        checks++;
        if (mem_q.size() != 0 || fill_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: %0d mem and %0d fill transfers missing, required 0",
                     name, mem_q.size(), fill_q.size());
        end
        mem_q.delete();
        fill_q.delete();
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
        mem_q.delete();
        fill_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (bus.miss_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle: miss_ready %b mem_req %b, required 1 0",
                     bus.miss_ready, bus.mem_req);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #2;
        checks++;
        if ({bus.miss_ready, bus.mem_req, bus.mem_we, bus.fill_we, bus.tag_we, bus.done, bus.cache_rd_en}
            !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_strobes: %b, required 1000000",
                     {bus.miss_ready, bus.mem_req, bus.mem_we, bus.fill_we, bus.tag_we, bus.done, bus.cache_rd_en});
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.fill_way !== '0 || bus.fill_word !== '0 ||
            bus.fill_index !== '0 || bus.done_way !== '0) begin
            errors++;
            $display("FAIL reset_datapath: addr %h way %0d word %0d idx %h done_way %0d, required all 0",
                     bus.mem_addr, bus.fill_way, bus.fill_word, bus.fill_index, bus.done_way);
        end
    endtask

    // First full-set miss after reset evicts dirty way 0 (rr_ptr 0 -> 1)
    task automatic test_dirty_evict();
        do_miss("dirty", 18'h2A5F3, 8'h12, 4'hF, 4'b0001, TAGS_A, 2'd0, 49, 1'b0);
    endtask

    // Clean fill into the invalid way 2; a following full-set miss proves rr_ptr stayed at 1
    task automatic test_clean_fill();
        do_miss("clean", 18'h2A5F3, 8'h12, 4'b1011, 4'b0000, TAGS_A, 2'd2, 17, 1'b0);
        do_miss("rr_kept", 18'h01234, 8'h40, 4'hF, 4'b0000, TAGS_B, 2'd1, 17, 1'b0);
    endtask

    // Five back-to-back misses to a full clean set from rr_ptr 0
    task automatic test_round_robin();
        logic [1:0] exp_v[5];
        exp_v = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset(2);
        for (int i = 0; i < 5; i++) begin
            do_miss($sformatf("rr%0d", i), 18'h10000 + 18'(i), 8'(8'h80 + i), 4'hF, 4'b0000,
                    TAGS_B, exp_v[i], 17, 1'b0);
        end
    endtask

    // Three wait states on fill word 5; a stray miss_valid mid-refill must be ignored
    task automatic test_stall();
        stall_word = 5;
        stall_left = 3;
        do_miss("stall", 18'h3FFFF, 8'hFF, 4'b0111, 4'b0111, TAGS_A, 2'd3, 20, 1'b1);
        stall_word = -1;
    endtask

    // Reset during the writeback of word 7, then a fresh dirty miss from rr_ptr 0
    task automatic test_reset_mid_writeback();
        int  start_done;
        int  start_tag;
        bit  hit = 1'b0;
        start_done = done_count;
        start_tag  = tag_we_count;
        push_expect(18'h15555, 8'h33, 2'd1, TAGS_B[18 +: 18], 1'b1);
        drive_miss("rmid", 18'h15555, 8'h33, 4'hF, 4'hF, TAGS_B);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1 && bus.mem_addr[5:2] == 4'd7) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rmid_word7: writeback of word 7 not seen, required within 100 cycles");
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #2;
        mem_q.delete();
        fill_q.delete();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.miss_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_abort: mem_req %b miss_ready %b, required 0 1", bus.mem_req, bus.miss_ready);
        end
        repeat (20) @(negedge clk);
        #2;
        checks++;
        if (done_count != start_done || tag_we_count != start_tag) begin
            errors++;
            $display("FAIL rmid_no_update: done %0d tag_we %0d after reset, required 0 0",
                     done_count - start_done, tag_we_count - start_tag);
        end
        do_miss("rmid_restart", 18'h15555, 8'h33, 4'hF, 4'hF, TAGS_B, 2'd0, 49, 1'b0);
    endtask

    initial begin
        bus.miss_valid = 1'b0;
        bus.miss_tag   = '0;
        bus.miss_index = '0;
        bus.set_valid  = '0;
        bus.set_dirty  = '0;
        bus.set_tags   = '0;
        test_reset();
        test_dirty_evict();
        test_clean_fill();
        test_round_robin();
        test_stall();
        test_reset_mid_writeback();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_refill_controller.md
# cache_refill_controller

Miss-handling sequencer for the 4-way set-associative cache. On a lookup miss it selects a victim way, writes a dirty victim line back to memory word by word, refills the line from memory, then updates the way's tag/valid/dirty bits. It sits between the cache lookup path, which raises the miss, and the single-word memory port. It owns the cache array write strobes for the duration of a refill.

## Interface
- WAYS, 4, associativity (victim pointer is $clog2(WAYS) bits)
- TAG_BITS, 18, tag width
- INDEX_BITS, 8, set index width
- OFFSET_BITS, 6, byte offset width; address = {tag, index, offset}
- DATA_WIDTH, 32, memory and array word width
- LINE_SIZE_BYTES, 64, line size; WORDS = LINE_SIZE_BYTES*8/DATA_WIDTH = 16; word counter is OFFSET_BITS-2 bits

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- miss_valid  in  1  miss request
- miss_ready  out  1  high only in IDLE
- miss_tag  in  TAG_BITS  tag of the missing address
- miss_index  in  INDEX_BITS  set of the missing address
- set_valid, set_dirty  in  WAYS each  per-way V/D bits of the addressed set
- set_tags  in  WAYS*TAG_BITS  per-way tags; way w at [w*TAG_BITS +: TAG_BITS]
- cache_rd_en  out  1  victim word read strobe
- cache_rd_way  out  $clog2(WAYS)  way to read
- cache_rd_index  out  INDEX_BITS  set to read
- cache_rd_word  out  OFFSET_BITS-2  word to read
- cache_rd_data  in  DATA_WIDTH  valid the cycle after cache_rd_en; held by the array until the next cache_rd_en
- fill_we  out  1  array word write strobe
- fill_way  out  $clog2(WAYS)  way to write
- fill_index  out  INDEX_BITS  set to write
- fill_word  out  OFFSET_BITS-2  word to write
- fill_data  out  DATA_WIDTH  data to write
- tag_we  out  1  tag update strobe; sets V=1, D=0, tag=latched miss_tag at fill_way/fill_index
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDRESS  {tag, index, word, 2'b00}, TAG+INDEX+OFFSET bits
- mem_wdata  out  DATA_WIDTH  equals cache_rd_data
- mem_ack  in  1  transfer completes on an edge where mem_req && mem_ack; mem_rdata valid then
- mem_rdata  in  DATA_WIDTH  read data
- done  out  1  one-cycle pulse when the refill is complete
- done_way  out  $clog2(WAYS)  way that was refilled; valid with done

## Operation
- States: IDLE, WB_RD, WB_WR, FILL, UPDATE.
- IDLE:
  - On miss_valid, latch miss_tag, miss_index, set_valid, set_dirty and set_tags.
  - Choose the victim: the lowest-numbered invalid way if one exists; otherwise rr_ptr, then rr_ptr += 1 (modulo WAYS).
  - Clear the word counter.
  - Go to WB_RD if the victim is valid and dirty, else to FILL.
- WB_RD: cache_rd_en=1 for (victim, index, word) for one cycle, then go to WB_WR.
- WB_WR:
  - Drive mem_req=1, mem_we=1, mem_addr={victim_tag, index, word, 00}, mem_wdata=cache_rd_data.
  - Hold until ack.
  - On ack: if word==WORDS-1, clear word and go to FILL; else word+1 and go to WB_RD.
- FILL:
  - Drive mem_req=1, mem_we=0, mem_addr={miss_tag, index, word, 00}.
  - On the ack cycle, fill_we=1 with fill_data=mem_rdata and fill_word=word.
  - After the last word go to UPDATE; else word+1.
- UPDATE: tag_we=1, done=1, done_way=victim for one cycle, then go to IDLE.
- miss_valid is ignored outside IDLE. Back-to-back misses: a new miss is accepted the cycle after done.
- rr_ptr is global, not per-set. It advances only when the set is full.

## Timing
- Reset (synchronous): state=IDLE, word=0, rr_ptr=0.
  - miss_ready=1 from the first cycle after reset.
  - All strobes (cache_rd_en, fill_we, tag_we, mem_req, mem_we, done) are 0.
  - Datapath outputs are 0.
- Reset mid-operation abandons the transaction: mem_req drops the next cycle, and no tag_we or done is issued. The line stays invalid or stale. The cache clears V at miss detection.
- Strobes are state decodes; fill_we is qualified by mem_ack.
- mem_req, mem_we, mem_addr and mem_wdata stay stable until ack.
- Latency with zero-wait ack (accept edge = cycle 0):
  - Clean miss: done in cycle WORDS+1 (17).
  - Dirty miss: done in cycle 3*WORDS+1 (49).
  - Each stall cycle adds 1.

## Test plan
- Reset: assert rst 2 cycles -> miss_ready=1, mem_req=0, fill_we=0, tag_we=0, done=0; the first full-set miss picks way 0.
- Clean fill into invalid way: set_valid=4'b1011, miss_tag=0x2A5F3, miss_index=0x12, mem_ack=1 -> no mem writes; 16 reads at 0xA97CC480..0xA97CC4BC step 4; fill_way=2; done in cycle 17, done_way=2; rr_ptr unchanged.
- Dirty eviction: set_valid=4'hF, set_dirty=4'b0001, way-0 tag=0x00001, index 0x12, rr_ptr=0 -> 16 writes to 0x00004480..0x000044BC carrying the array words, then 16 refill reads; tag_we at way 0; done in cycle 49; rr_ptr=1.
- Round-robin wrap: five misses to a full clean set -> victims 0,1,2,3,0.
- Memory stall: mem_ack low for 3 cycles on fill word 5 -> mem_addr held at word 5, no fill_we until ack, done delayed to cycle 20.
- Reset mid-writeback at word 7 -> next cycle mem_req=0, miss_ready=1, no tag_we or done; the next miss restarts at word 0 with victim selected from rr_ptr=0.
